pt_axi4lite_master: RTL and testbench

//  Converts a simple one-at-a-time command/response stream into AXI4-Lite master transactions.

---
 rtl/pt_axi4lite_master.sv | 176 +++++++++++++++++
 tb/tb_pt_axi4lite_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pt_axi4lite_master.sv
// Bridges a one-at-a-time command/response stream onto an AXI4-Lite master port.
// Only one transaction is in flight at a time, and every output comes straight from a flop.
module pt_axi4lite_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [DATA_W-1:0] i_cmd_data,
   input  logic [STRB_W-1:0] i_cmd_strb,
   input  logic              i_cmd_write,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic [1:0]        o_rsp_resp,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [ADDR_W-1:0] o_awaddr,
   output logic              o_awvalid,
   input  logic              i_awready,
   output logic [DATA_W-1:0] o_wdata,
   output logic [STRB_W-1:0] o_wstrb,
   output logic              o_wvalid,
   input  logic              i_wready,
   input  logic [1:0]        i_bresp,
   input  logic              i_bvalid,
   output logic              o_bready,
   output logic [ADDR_W-1:0] o_araddr,
   output logic              o_arvalid,
   input  logic              i_arready,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rvalid,
   output logic              o_rready,
   output logic [2:0]        o_state
);

   // Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1.
   // Once a valid is raised, it stays high and its payload stays fixed until that transfer.

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_REQ = 3'd1,
      WR_RSP = 3'd2,
      RD_REQ = 3'd3,
      RD_RSP = 3'd4,
      RSP    = 3'd5
   } state_t;

   state_t              state, state_n;
   logic                cmd_ready_n, rsp_valid_n, awvalid_n, wvalid_n;
   logic                bready_n, arvalid_n, rready_n;
   logic [DATA_W-1:0]   rsp_data_n, wdata_n;
   logic [1:0]          rsp_resp_n;
   logic [ADDR_W-1:0]   awaddr_n, araddr_n;
   logic [STRB_W-1:0]   wstrb_n;

   assign o_state = state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         o_cmd_ready <= 1'b0;
         o_rsp_data  <= '0;
         o_rsp_resp  <= '0;
         o_rsp_valid <= 1'b0;
         o_awaddr    <= '0;
         o_awvalid   <= 1'b0;
         o_wdata     <= '0;
         o_wstrb     <= '0;
         o_wvalid    <= 1'b0;
         o_bready    <= 1'b0;
         o_araddr    <= '0;
         o_arvalid   <= 1'b0;
         o_rready    <= 1'b0;
      end else begin
         state       <= state_n;
         o_cmd_ready <= cmd_ready_n;
         o_rsp_data  <= rsp_data_n;
         o_rsp_resp  <= rsp_resp_n;
         o_rsp_valid <= rsp_valid_n;
         o_awaddr    <= awaddr_n;
         o_awvalid   <= awvalid_n;
         o_wdata     <= wdata_n;
         o_wstrb     <= wstrb_n;
         o_wvalid    <= wvalid_n;
         o_bready    <= bready_n;
         o_araddr    <= araddr_n;
         o_arvalid   <= arvalid_n;
         o_rready    <= rready_n;
      end
   end

   always_comb begin
      state_n     = state;
      cmd_ready_n = o_cmd_ready;
      rsp_data_n  = o_rsp_data;
      rsp_resp_n  = o_rsp_resp;
      rsp_valid_n = o_rsp_valid;
      awaddr_n    = o_awaddr;
      awvalid_n   = o_awvalid;
      wdata_n     = o_wdata;
      wstrb_n     = o_wstrb;
      wvalid_n    = o_wvalid;
      bready_n    = o_bready;
      araddr_n    = o_araddr;
      arvalid_n   = o_arvalid;
      rready_n    = o_rready;

      case (state)
         IDLE: begin
            cmd_ready_n = 1'b1;
            if (i_cmd_valid && o_cmd_ready) begin
               cmd_ready_n = 1'b0;
               if (i_cmd_write) begin
                  awaddr_n  = i_cmd_addr;
                  wdata_n   = i_cmd_data;
                  wstrb_n   = i_cmd_strb;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  state_n   = WR_REQ;
               end else begin
                  araddr_n  = i_cmd_addr;
                  arvalid_n = 1'b1;
                  state_n   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            // AW and W retire independently; B is only accepted once both have gone.
            if (o_awvalid && i_awready) awvalid_n = 1'b0;
            if (o_wvalid && i_wready)   wvalid_n  = 1'b0;
            if (!awvalid_n && !wvalid_n) begin
               bready_n = 1'b1;
               state_n  = WR_RSP;
            end
         end
         WR_RSP: begin
            if (i_bvalid && o_bready) begin
               rsp_resp_n  = i_bresp;
               rsp_data_n  = '0;
               rsp_valid_n = 1'b1;
               bready_n    = 1'b0;
               state_n     = RSP;
            end
         end
         RD_REQ: begin
            if (o_arvalid && i_arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = RD_RSP;
            end
         end
         RD_RSP: begin
            if (i_rvalid && o_rready) begin
               rsp_data_n  = i_rdata;
               rsp_resp_n  = i_rresp;
               rsp_valid_n = 1'b1;
               rready_n    = 1'b0;
               state_n     = RSP;
            end
         end
         RSP: begin
            if (i_rsp_ready) begin
               rsp_valid_n = 1'b0;
               cmd_ready_n = 1'b1;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pt_axi4lite_master.sv
// Bench for pt_axi4lite_master: directed corner cases followed by a random mix of reads and writes
// driven against a cycle-level AXI slave model, with responses compared through an expected queue.
module tb_pt_axi4lite_master;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int STRB_W = DATA_W / 8;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic [ADDR_W-1:0] i_cmd_addr;
   logic [DATA_W-1:0] i_cmd_data;
   logic [STRB_W-1:0] i_cmd_strb;
   logic              i_cmd_write, i_cmd_valid, o_cmd_ready;
   logic [DATA_W-1:0] o_rsp_data;
   logic [1:0]        o_rsp_resp;
   logic              o_rsp_valid, i_rsp_ready;
   logic [ADDR_W-1:0] o_awaddr, o_araddr;
   logic              o_awvalid, i_awready, o_wvalid, i_wready;
   logic [DATA_W-1:0] o_wdata, i_rdata;
   logic [STRB_W-1:0] o_wstrb;
   logic [1:0]        i_bresp, i_rresp;
   logic              i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
   logic [2:0]        o_state;

   pt_axi4lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
      .i_cmd_write(i_cmd_write), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_resp(o_rsp_resp), .o_rsp_valid(o_rsp_valid),
      .i_rsp_ready(i_rsp_ready),
      .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
      .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
      .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
      .o_state(o_state)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;
   logic [DATA_W+1:0] exp_q[$];

   // random-phase slave model state
   int                issued, completed, cycles, b_delay, r_delay;
   logic              busy, cur_write, aw_done, w_done, ar_done;
   logic              cmd_hs, b_hs, r_hs, aw_hold, rsp_hold;
   logic [ADDR_W-1:0] cur_addr, hold_addr;
   logic [DATA_W-1:0] cur_data, cur_rdata;
   logic [STRB_W-1:0] cur_strb;
   logic [1:0]        cur_resp;
   logic [DATA_W+1:0] hold_rsp;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic check_rsp(input string tag);
      logic [DATA_W+1:0] e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: observed response %0h expected nothing queued", tag, {o_rsp_data, o_rsp_resp});
      end else begin
         e = exp_q.pop_front();
         check(tag, {o_rsp_data, o_rsp_resp}, e);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
      i_cmd_write = wr;
      i_cmd_addr  = a;
      i_cmd_data  = d;
      i_cmd_strb  = s;
      i_cmd_valid = 1'b1;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_cmd_addr = '0; i_cmd_data = '0; i_cmd_strb = '0; i_cmd_write = 1'b0; i_cmd_valid = 1'b0;
      i_rsp_ready = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
      i_bresp = '0; i_bvalid = 1'b0; i_rdata = '0; i_rresp = '0; i_rvalid = 1'b0;

      // reset values
      repeat (2) tick();
      check("rst_cmd_ready", o_cmd_ready, 0);
      check("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_rsp_valid}, 0);
      check("rst_readies", {o_bready, o_rready}, 0);
      check("rst_payload", {o_rsp_data, o_rsp_resp, o_awaddr, o_araddr, o_wdata, o_wstrb}, 0);
      check("rst_state_idle", o_state, 0);
      i_rst_n = 1'b1;
      tick();
      check("idle_cmd_ready", o_cmd_ready, 1);

      // minimum-latency write
      i_awready = 1'b1; i_wready = 1'b1; i_arready = 1'b1;
      drive_cmd(1'b1, 32'h10, 64'hDEAD_BEEF, 8'hFF);
      tick();
      i_cmd_valid = 1'b0;
      exp_q.push_back({64'h0, 2'b00});
      check("t1_aw_w_valid", {o_awvalid, o_wvalid}, 2'b11);
      check("t1_awaddr", o_awaddr, 32'h10);
      check("t1_wdata", o_wdata, 64'hDEAD_BEEF);
      check("t1_wstrb", o_wstrb, 8'hFF);
      check("t1_cmd_ready_low", o_cmd_ready, 0);
      tick();
      check("t1_aw_w_drop", {o_awvalid, o_wvalid}, 2'b00);
      check("t1_bready", o_bready, 1);
      i_bvalid = 1'b1; i_bresp = 2'b00;
      tick();
      i_bvalid = 1'b0;
      check("t1_rsp_valid", o_rsp_valid, 1);
      check("t1_bready_low", o_bready, 0);
      check_rsp("t1_rsp");
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      check("t1_rsp_done", {o_rsp_valid, o_cmd_ready}, 2'b01);

      // write with AW held off three cycles; stray B while bready is low must be ignored
      i_awready = 1'b0; i_wready = 1'b1;
      drive_cmd(1'b1, 32'h40, 64'h0123_4567_89AB_CDEF, 8'h0F);
      tick();
      i_cmd_valid = 1'b0;
      check("t2_c1_valids", {o_awvalid, o_wvalid}, 2'b11);
      i_bvalid = 1'b1; i_bresp = 2'b11;
      tick();
      check("t2_c2_w_dropped", {o_awvalid, o_wvalid}, 2'b10);
      check("t2_c2_bready_low", o_bready, 0);
      tick();
      check("t2_c3_aw_held", {o_awvalid, o_rsp_valid}, 2'b10);
      tick();
      i_bvalid = 1'b0;
      check("t2_c4_aw_held", {o_awvalid, o_awaddr}, {1'b1, 32'h40});
      i_awready = 1'b1;
      tick();
      check("t2_c5_aw_done", {o_awvalid, o_bready, o_rsp_valid}, 3'b010);
      exp_q.push_back({64'h0, 2'b10});
      i_bvalid = 1'b1; i_bresp = 2'b10;
      tick();
      i_bvalid = 1'b0;
      check("t2_rsp_valid", {o_rsp_valid, o_bready}, 2'b10);
      check_rsp("t2_rsp");
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      tick();
      check("t2_single_b", {o_rsp_valid, o_cmd_ready}, 2'b01);

      // read with slow R and SLVERR
      drive_cmd(1'b0, 32'h20, 64'h0, 8'h0);
      tick();
      i_cmd_valid = 1'b0;
      check("t3_arvalid", {o_arvalid, o_awvalid}, 2'b10);
      check("t3_araddr", o_araddr, 32'h20);
      tick();
      check("t3_ar_done", {o_arvalid, o_rready}, 2'b01);
      repeat (4) begin
         tick();
         check("t3_wait_r", {o_rsp_valid, o_rready}, 2'b01);
      end
      exp_q.push_back({64'h1234, 2'b10});
      i_rvalid = 1'b1; i_rdata = 64'h1234; i_rresp = 2'b10;
      tick();
      i_rvalid = 1'b0;
      check("t3_rsp_valid", {o_rsp_valid, o_rready}, 2'b10);
      check_rsp("t3_rsp");

      // response back-pressure with a new command waiting
      drive_cmd(1'b0, 32'h30, 64'h0, 8'h0);
      repeat (4) begin
         tick();
         check("t4_rsp_held", {o_rsp_valid, o_rsp_data, o_rsp_resp}, {1'b1, 64'h1234, 2'b10});
         check("t4_cmd_blocked", o_cmd_ready, 0);
         check("t4_no_axi", {o_awvalid, o_wvalid, o_arvalid}, 0);
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      check("t4_rsp_done", {o_rsp_valid, o_cmd_ready}, 2'b01);
      tick();
      i_cmd_valid = 1'b0;
      check("t4_next_ar", {o_arvalid, o_araddr}, {1'b1, 32'h30});
      tick();
      exp_q.push_back({64'hFEED_0000_ABCD, 2'b00});
      i_rvalid = 1'b1; i_rdata = 64'hFEED_0000_ABCD; i_rresp = 2'b00;
      tick();
      i_rvalid = 1'b0;
      check_rsp("t4_rsp2");
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;

      // asynchronous reset while AW/W are pending
      i_awready = 1'b0; i_wready = 1'b0;
      drive_cmd(1'b1, 32'h80, 64'h77, 8'h01);
      tick();
      i_cmd_valid = 1'b0;
      check("t5_aw_pending", {o_awvalid, o_wvalid}, 2'b11);
      #3;
      i_rst_n = 1'b0;
      #1;
      check("t5_async_clear", {o_awvalid, o_wvalid, o_cmd_ready, o_state}, 0);
      tick();
      i_rst_n = 1'b1;
      tick();
      check("t5_post_rst", {o_cmd_ready, o_state, o_awvalid, o_wvalid}, {1'b1, 3'd0, 2'b00});

      // random back-to-back mix
      busy = 1'b0; issued = 0; completed = 0; cycles = 0;
      aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0; b_delay = 0; r_delay = 0;
      cur_write = 1'b0; cur_addr = '0; cur_data = '0; cur_strb = '0; cur_rdata = '0; cur_resp = '0;
      while (completed < 200 && cycles < 20000) begin
         @(negedge i_clk);
         cycles++;
         if (!i_cmd_valid && issued < 200 && $urandom_range(0, 2) != 0) begin
            drive_cmd(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
                      8'($urandom_range(0, 255)));
            issued++;
         end
         i_awready   = 1'($urandom_range(0, 1));
         i_wready    = 1'($urandom_range(0, 1));
         i_arready   = 1'($urandom_range(0, 1));
         i_rsp_ready = ($urandom_range(0, 2) != 0);
         if (aw_done && w_done && !i_bvalid) begin
            if (b_delay == 0) begin
               i_bvalid = 1'b1; i_bresp = cur_resp;
            end else b_delay--;
         end
         if (ar_done && !i_rvalid) begin
            if (r_delay == 0) begin
               i_rvalid = 1'b1; i_rdata = cur_rdata; i_rresp = cur_resp;
            end else r_delay--;
         end

         check("r_idle_quiet", (o_awvalid | o_wvalid | o_arvalid | o_rsp_valid) & ~busy, 0);
         cmd_hs = i_cmd_valid && o_cmd_ready;
         if (cmd_hs) begin
            check("r_one_outstanding", busy, 0);
            busy      = 1'b1;
            cur_write = i_cmd_write;
            cur_addr  = i_cmd_addr;
            cur_data  = i_cmd_data;
            cur_strb  = i_cmd_strb;
            cur_resp  = 2'($urandom_range(0, 3));
            cur_rdata = {$urandom, $urandom};
            b_delay   = $urandom_range(0, 3);
            r_delay   = $urandom_range(0, 3);
            exp_q.push_back({(cur_write ? {DATA_W{1'b0}} : cur_rdata), cur_resp});
         end
         if (o_awvalid && i_awready) begin
            check("r_awaddr", {cur_write, o_awaddr}, {1'b1, cur_addr});
            aw_done = 1'b1;
         end
         if (o_wvalid && i_wready) begin
            check("r_wdata", {o_wdata, o_wstrb}, {cur_data, cur_strb});
            w_done = 1'b1;
         end
         if (o_arvalid && i_arready) begin
            check("r_araddr", {cur_write, o_araddr}, {1'b0, cur_addr});
            ar_done = 1'b1;
         end
         b_hs = i_bvalid && o_bready;
         r_hs = i_rvalid && o_rready;
         if (o_rsp_valid && i_rsp_ready) begin
            check_rsp("r_rsp");
            busy = 1'b0;
            completed++;
         end
         aw_hold   = o_awvalid && !i_awready;
         hold_addr = o_awaddr;
         rsp_hold  = o_rsp_valid && !i_rsp_ready;
         hold_rsp  = {o_rsp_data, o_rsp_resp};

         @(posedge i_clk);
         #1;
         if (cmd_hs) i_cmd_valid = 1'b0;
         if (b_hs) begin
            i_bvalid = 1'b0; aw_done = 1'b0; w_done = 1'b0;
         end
         if (r_hs) begin
            i_rvalid = 1'b0; ar_done = 1'b0;
         end
         if (aw_hold) check("r_aw_stable", {o_awvalid, o_awaddr}, {1'b1, hold_addr});
         if (rsp_hold) check("r_rsp_stable", {o_rsp_valid, o_rsp_data, o_rsp_resp}, {1'b1, hold_rsp});
      end
      check("r_all_completed", completed, 200);
      check("r_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
